// File: rtl/div32_if.sv
// Request/response bundle between the EX-stage issue logic (master) and the
// iterative divider (slave).
interface div32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             ready;
  logic             div_zero;

  modport master (
    output start, cancel, sign, a, b,
    input  q, r, busy, ready, div_zero
  );

  modport slave (
    input  start, cancel, sign, a, b,
    output q, r, busy, ready, div_zero
  );
endinterface

// File: rtl/div32_seq.sv
// Iterative restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// Optional macro DIV32_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip RUN.
module div32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic   clk,
  input  logic   clrn,
  div32_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] a_orig_reg;
  logic             sign_reg;
  logic             sign_a_reg;
  logic             sign_b_reg;
  logic             b_zero_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic             busy_reg;
  logic             ready_reg;
  logic             div_zero_reg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shift_rem;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign a_neg = bus.sign & bus.a[WIDTH-1];
  assign b_neg = bus.sign & bus.b[WIDTH-1];
  assign abs_a = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign abs_b = b_neg ? (~bus.b + 1'b1) : bus.b;

  // The shifted remainder can exceed WIDTH bits; if its top bit is set the
  // subtract always succeeds, so only the low WIDTH bits need the borrow check.
  assign shift_rem = {rem_reg, dvd_reg[WIDTH-1]};
  assign trial     = {1'b0, shift_rem[WIDTH-1:0]} - {1'b0, dvs_reg};
  assign trial_ok  = shift_rem[WIDTH] | ~trial[WIDTH];
  assign rem_next  = trial_ok ? trial[WIDTH-1:0] : shift_rem[WIDTH-1:0];
  assign dvd_next  = {dvd_reg[WIDTH-2:0], trial_ok};

  assign q_fix = b_zero_reg ? {WIDTH{1'b1}} :
                 (sign_reg && (sign_a_reg != sign_b_reg)) ? (~dvd_reg + 1'b1) : dvd_reg;
  assign r_fix = b_zero_reg ? a_orig_reg :
                 (sign_reg && sign_a_reg) ? (~rem_reg + 1'b1) : rem_reg;

`ifdef DIV32_FAST_SPECIAL_EN
  logic fast_special;
  // Overflow needs no special load: |0x80000000| / 1 with equal sign flags is already correct.
  assign fast_special = (bus.b == '0) ||
                        (bus.sign && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == {WIDTH{1'b1}}));
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rem_reg      <= '0;
      dvd_reg      <= '0;
      dvs_reg      <= '0;
      a_orig_reg   <= '0;
      sign_reg     <= 1'b0;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      b_zero_reg   <= 1'b0;
      q_reg        <= '0;
      r_reg        <= '0;
      busy_reg     <= 1'b0;
      ready_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      if (bus.cancel) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.start) begin
              sign_reg   <= bus.sign;
              sign_a_reg <= bus.a[WIDTH-1];
              sign_b_reg <= bus.b[WIDTH-1];
              b_zero_reg <= (bus.b == '0);
              a_orig_reg <= bus.a;
              dvd_reg    <= abs_a;
              dvs_reg    <= abs_b;
              rem_reg    <= '0;
              cnt_reg    <= '0;
              busy_reg   <= 1'b1;
`ifdef DIV32_FAST_SPECIAL_EN
              state_reg  <= fast_special ? FIX : RUN;
`else
              state_reg  <= RUN;
`endif
            end
          end
          RUN: begin
            rem_reg <= rem_next;
            dvd_reg <= dvd_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(WIDTH - 1)) begin
              state_reg <= FIX;
            end
          end
          FIX: begin
            q_reg        <= q_fix;
            r_reg        <= r_fix;
            div_zero_reg <= b_zero_reg;
            ready_reg    <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.q        = q_reg;
  assign bus.r        = r_reg;
  assign bus.busy     = busy_reg;
  assign bus.ready    = ready_reg;
  assign bus.div_zero = div_zero_reg;

endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
- Iterative 32-bit integer divider, the subtract-based inverse of the 32-bit carry-lookahead adder in the integer datapath.
- Implements RISC-V M-extension DIV/DIVU/REM/REMU semantics.
- Sits in the EX stage beside the ALU. The pipeline stalls on busy and accepts results on ready.
- Uses a cancel input so interrupt or flush logic can abort an in-flight divide.

Parameters:
- WIDTH, 32, operand and result width; only 32 is verified.
- CNT_W, 5, iteration counter width; equals log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- clrn  input  1  asynchronous active-low reset
- start  input  1  request a divide; sampled only in IDLE
- cancel  input  1  abort the current operation (flush/interrupt)
- sign  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with start
- a  input  32  dividend; sampled with start
- b  input  32  divisor; sampled with start
- q  output  32  quotient; registered, held until the next completion
- r  output  32  remainder; registered, held until the next completion
- busy  output  1  high in RUN and FIX
- ready  output  1  one-cycle pulse; q/r valid in that cycle
- div_zero  output  1  registered with q/r; 1 when the completed op had b == 0

Behaviour:
- Reset (clrn low, asynchronous): state IDLE; q = 0, r = 0, busy = 0, ready = 0, div_zero = 0; counter and working registers cleared.
- States and transitions:
  - IDLE: start && !cancel -> RUN.
  - RUN: 32 iterations -> FIX.
  - FIX: one cycle -> IDLE.
- Edge E0 (start sampled in IDLE):
  - Latch sign, sign_a, sign_b, b_zero.
  - Latch |a| and |b| when sign = 1; raw values otherwise. |0x80000000| = 0x80000000 unsigned.
  - Clear partial remainder; counter = 0.
- RUN, edges E1..E32, restoring algorithm:
  - Shift {rem, dvd} left by 1.
  - Compute a 33-bit trial subtract rem - divisor.
  - If non-negative: keep the difference and set quotient bit = 1; otherwise restore and set bit = 0.
  - Counter increments; leave RUN when the counter wraps from 31.
- FIX, edge E33:
  - Signed quotient is negated if sign_a != sign_b; signed remainder takes the sign of the dividend.
  - b == 0: q = 0xFFFFFFFF, r = a (original), div_zero = 1. This is forced, overriding sign correction.
  - Signed 0x80000000 / 0xFFFFFFFF: q = 0x80000000, r = 0. The natural result is correct; no special path.
  - Register q, r, div_zero; ready = 1; state -> IDLE.
- Latency: ready is high after the 33rd rising edge following E0. busy is high after E0 through E33 exclusive.
- ready drops after the next edge.
- start while busy is ignored.
- start in the ready cycle (state IDLE) is accepted, giving back-to-back operation; q/r stay stable until the next FIX.
- cancel:
  - Any state -> IDLE on the next edge; busy = 0; no ready pulse; q/r/div_zero keep their prior values.
  - cancel with start in the same cycle: cancel wins; nothing is started.
- Reset asserted mid-operation: immediate return to reset values; no ready is produced.

Optional Feature:
- Macro DIV32_FAST_SPECIAL_EN.
- When defined:
  - At E0, if b == 0, or sign = 1 && a == 0x80000000 && b == 0xFFFFFFFF, the block skips RUN.
  - E0 loads the special results and goes directly to FIX; ready is high after E1 (busy high for one cycle).
  - All other operands behave as without the macro.
- When undefined: every operation takes the full 33-edge latency. Results are identical in both builds.

Test Plan:
- Unsigned: sign=0, a=100, b=7, start one cycle -> after 33 edges ready=1, q=14, r=2, div_zero=0; busy low in the ready cycle.
- Signed: sign=1, a=0xFFFFFFF9 (-7), b=2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Also a=7, b=0xFFFFFFFE -> q=0xFFFFFFFD, r=1.
- Divide by zero:
  - sign=1, a=0xFFFFFFFB, b=0 -> q=0xFFFFFFFF, r=0xFFFFFFFB, div_zero=1.
  - Ready after 33 edges, or after 1 edge with DIV32_FAST_SPECIAL_EN.
- Overflow and back-to-back:
  - sign=1, a=0x80000000, b=0xFFFFFFFF -> q=0x80000000, r=0.
  - Assert start again in the ready cycle with DIVU 0xFFFFFFFF/0x10 -> next result q=0x0FFFFFFF, r=0xF.
- Cancel: start 1000/3, assert cancel on edge 10 -> busy low after that edge, no ready ever, q/r still show the previous result. A fresh 1000/3 then yields q=333, r=1.
- Reset: pull clrn low asynchronously mid-RUN (between edges) -> q=r=0, busy=ready=div_zero=0 immediately. After release, 9/3 -> q=3, r=0.
